filter_window_gen: RTL and testbench

FILTER_WINDOW_GEN -- requirements
Module: filter_window_gen

---
 rtl/filter_window_gen.sv | 215 +++++++++++++++++++++
 tb/tb_filter_window_gen.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/filter_window_gen.sv
// filter_window_gen
//
// Builds a sliding SIZE x SIZE (fixed 5x5) window of 8-bit pixels from a
// raster-order pixel stream. Four line buffers hold the previous four lines.
// A window register array shifts one column left per accepted pixel. A window
// is emitted one cycle after the pixel that completes it. Only full windows
// are emitted: rows 0..3 and columns 0..3 of each frame produce no output.
//
// Ports
//   clk        : clock; all state updates on its rising edge
//   rst_n      : asynchronous active-low reset
//   in_pixel   : raster-order pixel (row-major, left to right, top to bottom)
//   in_valid   : in_pixel is valid
//   in_ready   : block accepts a pixel (= !out_valid || out_ready)
//   in_sof     : only with FILTER_WINDOW_SOF_EN; forces the accepted pixel
//                to position (0,0)
//   out_window : element (row i, col j) at bits [i*40 + j*8 +: 8];
//                row 0 is the oldest line, col 0 is the leftmost column
//   out_valid  : out_window is valid
//   out_ready  : downstream accepts the window
//
// Configuration macro
//   FILTER_WINDOW_SOF_EN : adds the in_sof input. Undefined by default, so
//                          frame alignment comes only from the counters and
//                          reset.

module filter_window_gen #(
  parameter int unsigned IMG_WIDTH  = 64,  // 5..1024
  parameter int unsigned IMG_HEIGHT = 64,  // 5..1024
  parameter int unsigned SIZE       = 5    // window edge, only 5 supported
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [7:0]               in_pixel,
  input  logic                     in_valid,
`ifdef FILTER_WINDOW_SOF_EN
  input  logic                     in_sof,
`endif
  output logic                     in_ready,
  output logic [8*SIZE*SIZE-1:0]   out_window,
  output logic                     out_valid,
  input  logic                     out_ready
);

  localparam int unsigned CW  = $clog2(IMG_WIDTH);
  localparam int unsigned RW  = $clog2(IMG_HEIGHT);
  localparam int unsigned NLB = SIZE - 1;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] COL_EDGE = CW'(SIZE - 1);
  localparam logic [RW-1:0] ROW_EDGE = RW'(SIZE - 1);

  // Position counters
  logic [CW-1:0] col_q, col_d, col_cur;
  logic [RW-1:0] row_q, row_d, row_cur;

  logic          accept;
  logic          sof;
  logic          win_done;
  logic          out_valid_q, out_valid_d;

  // Line buffers: lb_mem[0] is the most recent previous line
  logic [7:0]    lb_mem [NLB][IMG_WIDTH];
  logic [7:0]    lb_rd  [NLB];

  // Window registers and the column entering on the next accept
  logic [7:0]    win_q   [SIZE][SIZE];
  logic [7:0]    new_col [SIZE];

  //--------------------------------------------------------------------------
  // Handshake
  //--------------------------------------------------------------------------
  // A pending window that has not been taken blocks new pixels, which keeps
  // the window registers (and therefore out_window) stable while stalled.
  assign in_ready  = !out_valid_q || out_ready;
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;

`ifdef FILTER_WINDOW_SOF_EN
  assign sof = in_sof;
`else
  assign sof = 1'b0;
`endif

  //--------------------------------------------------------------------------
  // Position of the pixel being presented
  //--------------------------------------------------------------------------
  // A start-of-frame pixel is placed at (0,0) regardless of the counters.
  always_comb begin
    col_cur = col_q;
    row_cur = row_q;
    if (sof) begin
      col_cur = '0;
      row_cur = '0;
    end
  end

  // The pixel closes a full window only once four lines and four columns of
  // the current frame lie above and left of it.
  assign win_done = (row_cur >= ROW_EDGE) && (col_cur >= COL_EDGE);

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      if (col_cur == COL_LAST) begin
        col_d = '0;
        row_d = (row_cur == ROW_LAST) ? '0 : row_cur + 1'b1;
      end else begin
        col_d = col_cur + 1'b1;
        row_d = row_cur;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  //--------------------------------------------------------------------------
  // Line buffers
  //--------------------------------------------------------------------------
  // Not reset: stale contents only reach rows of the window that are fully
  // overwritten before the first window of a frame is emitted.
  always_comb begin
    for (int k = 0; k < NLB; k++) begin
      lb_rd[k] = lb_mem[k][col_cur];
    end
  end

  // Each accepted pixel pushes the column down one line: the new pixel goes
  // into the newest buffer and every buffer hands its old value to the next.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb_mem[0][col_cur] <= in_pixel;
      for (int k = 1; k < NLB; k++) begin
        lb_mem[k][col_cur] <= lb_rd[k-1];
      end
    end
  end

  //--------------------------------------------------------------------------
  // Window registers
  //--------------------------------------------------------------------------
  // Row 0 is the oldest line, so it takes the deepest line buffer; the last
  // row takes the incoming pixel itself.
  always_comb begin
    for (int i = 0; i < SIZE; i++) begin
      new_col[i] = '0;
    end
    for (int i = 0; i < SIZE - 1; i++) begin
      new_col[i] = lb_rd[SIZE-2-i];
    end
    new_col[SIZE-1] = in_pixel;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SIZE; i++) begin
        for (int j = 0; j < SIZE; j++) begin
          win_q[i][j] <= '0;
        end
      end
    end else if (accept) begin
      for (int i = 0; i < SIZE; i++) begin
        for (int j = 0; j < SIZE - 1; j++) begin
          win_q[i][j] <= win_q[i][j+1];
        end
        win_q[i][SIZE-1] <= new_col[i];
      end
    end
  end

  //--------------------------------------------------------------------------
  // Output valid
  //--------------------------------------------------------------------------
  // A completing pixel accepted on the same edge as a transfer keeps
  // out_valid high, giving back-to-back windows.
  always_comb begin
    out_valid_d = out_valid_q;
    if (accept && win_done) begin
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
    end
  end

  //--------------------------------------------------------------------------
  // Window packing
  //--------------------------------------------------------------------------
  always_comb begin
    out_window = '0;
    for (int i = 0; i < SIZE; i++) begin
      for (int j = 0; j < SIZE; j++) begin
        out_window[(i*SIZE+j)*8 +: 8] = win_q[i][j];
      end
    end
  end

endmodule

// File: tb/tb_filter_window_gen.sv
// Testbench for filter_window_gen on an 8x8 image. The driver keeps a
// reference image of the current frame and, for every accepted pixel that
// closes a 5x5 window, pushes the expected window taken directly from that
// image. The monitor pops and compares on every output transfer.

module tb_filter_window_gen;

  localparam int W = 8;
  localparam int H = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [7:0]   in_pixel = '0;
  logic         in_valid = 1'b0;
`ifdef FILTER_WINDOW_SOF_EN
  logic         in_sof = 1'b0;
`endif
  logic         in_ready;
  logic [199:0] out_window;
  logic         out_valid;
  logic         out_ready = 1'b1;

  filter_window_gen #(
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H),
    .SIZE      (5)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_pixel  (in_pixel),
    .in_valid  (in_valid),
`ifdef FILTER_WINDOW_SOF_EN
    .in_sof    (in_sof),
`endif
    .in_ready  (in_ready),
    .out_window(out_window),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [199:0] win;
    int           cyc;
  } exp_t;

  exp_t         q[$];
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  int           win_cnt = 0;
  bit           pattern_phase = 0;
  logic [7:0]   img [H][W];
  int           pr = 0;
  int           pc = 0;

  // Monitor history
  bit           prev_valid = 0;
  bit           prev_xfer = 0;
  bit           prev_stall = 0;
  logic [199:0] prev_win = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string name, input logic [199:0] act, input logic [199:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int el(input logic [199:0] w, input int i, input int j);
    return int'(w[(i*5+j)*8 +: 8]);
  endfunction

  // Window whose bottom-right pixel sits at (pr, pc) of the reference image
  function automatic logic [199:0] ref_window();
    logic [199:0] w = '0;
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++)
        w[(i*5+j)*8 +: 8] = img[pr-4+i][pc-4+j];
    return w;
  endfunction

  // Monitor: sampled on the falling edge, deciding the coming rising edge
  always @(negedge clk) begin
    if (!rst_n) begin
      check_eq("reset_out_valid", out_valid, 0);
      check_eq("reset_out_window", out_window, 0);
      check_eq("reset_in_ready", in_ready, 1);
      q.delete();
      win_cnt    = 0;
      prev_valid = 0;
      prev_xfer  = 0;
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        check_eq("stall_valid_hold", out_valid, 1);
        check_eq("stall_window_hold", out_window, prev_win);
      end
      check_eq("in_ready", in_ready, !out_valid || out_ready);
      if (out_valid) begin
        if (q.size() == 0) begin
          check_eq("spurious_out_valid", out_valid, 0);
        end else begin
          if (!prev_valid || prev_xfer) check_eq("latency", cyc, q[0].cyc + 1);
          if (out_ready) begin
            check_eq("window", out_window, q[0].win);
            if (pattern_phase && (win_cnt % 16 == 0)) begin
              for (int j = 0; j < 5; j++) begin
                check_eq("first_row0", el(out_window, 0, j), j);
                check_eq("first_row4", el(out_window, 4, j), 32 + j);
              end
              check_eq("first_center", el(out_window, 2, 2), 18);
            end
            if (pattern_phase && (win_cnt % 16 == 15)) begin
              check_eq("last_bottom_right", el(out_window, 4, 4), 63);
              check_eq("last_center", el(out_window, 2, 2), 45);
            end
            void'(q.pop_front());
            win_cnt++;
          end
        end
      end else if (q.size() > 0 && q[0].cyc + 1 <= cyc) begin
        check_eq("missing_window", out_valid, 1);
        void'(q.pop_front());
      end
      prev_valid = out_valid;
      prev_xfer  = out_valid && out_ready;
      prev_stall = out_valid && !out_ready;
      prev_win   = out_window;
    end
  end

  // vmode: 0 continuous, 1 toggling, 2 random
  // rmode: 0 always ready, 1 five-cycle stall on the first window, 2 random
  // sof_idx: pixel index carrying in_sof (-1 none); rst_after: reset after
  // this many accepted pixels (-1 none)
  task automatic send(input int n, input bit pattern, input int vmode, input int rmode,
                      input int sof_idx, input int rst_after);
    int         i = 0;
    int         guard = 0;
    int         stall_left = 5;
    bit         tog = 1;
    logic [7:0] pix;
    pix = pattern ? 8'(pr * W + pc) : 8'($urandom);
    while (i < n) begin
      in_pixel = pix;
`ifdef FILTER_WINDOW_SOF_EN
      in_sof = (i == sof_idx);
`endif
      case (vmode)
        0:       in_valid = 1'b1;
        1:       begin in_valid = tog; tog = !tog; end
        default: in_valid = ($urandom_range(0, 3) != 0);
      endcase
      case (rmode)
        0: out_ready = 1'b1;
        1: begin
          if (stall_left > 0 && out_valid) begin
            out_ready = 1'b0;
            stall_left--;
          end else begin
            out_ready = 1'b1;
          end
        end
        default: out_ready = ($urandom_range(0, 2) != 0);
      endcase
      @(negedge clk);
      if (in_valid && in_ready) begin
        if (i == sof_idx) begin
          pr = 0;
          pc = 0;
        end
        img[pr][pc] = pix;
        if (pr >= 4 && pc >= 4) q.push_back('{win: ref_window(), cyc: cyc});
        if (pc == W - 1) begin
          pc = 0;
          pr = (pr == H - 1) ? 0 : pr + 1;
        end else begin
          pc++;
        end
        i++;
        pix = pattern ? 8'(pr * W + pc) : 8'($urandom);
        if (i == rst_after) begin
          @(posedge clk);
          #1;
          rst_n    = 1'b0;
          in_valid = 1'b0;
          #1;
          check_eq("reset_immediate_valid", out_valid, 0);
          check_eq("reset_immediate_ready", in_ready, 1);
          repeat (3) @(posedge clk);
          #1;
          rst_n = 1'b1;
          pr    = 0;
          pc    = 0;
`ifdef FILTER_WINDOW_SOF_EN
          in_sof = 1'b0;
`endif
          return;
        end
      end
      @(posedge clk);
      #1;
      guard++;
      if (guard > 20 * n + 100) begin
        check_eq("drive_timeout", i, n);
        break;
      end
    end
    in_valid = 1'b0;
`ifdef FILTER_WINDOW_SOF_EN
    in_sof = 1'b0;
`endif
  endtask

  task automatic drain(input string name, input int exp_windows);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check_eq({name, "_queue_empty"}, q.size(), 0);
    check_eq({name, "_window_count"}, win_cnt, exp_windows);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Two back-to-back ramp frames, fully streaming
    pattern_phase = 1;
    win_cnt = 0;
    send(128, 1, 0, 0, -1, -1);
    drain("two_frames", 32);

    // Downstream stall of five cycles on the first window
    win_cnt = 0;
    send(64, 1, 0, 1, -1, -1);
    drain("stall", 16);

    // in_valid toggling every cycle
    win_cnt = 0;
    send(64, 1, 1, 0, -1, -1);
    drain("toggle", 16);

    // Random pixels with random valid and ready
    pattern_phase = 0;
    win_cnt = 0;
    send(192, 0, 2, 2, -1, -1);
    drain("random", 48);

    // Reset after pixel 40, then a full frame
    pattern_phase = 1;
    send(64, 1, 0, 0, -1, 41);
    win_cnt = 0;
    send(64, 1, 0, 0, -1, -1);
    drain("after_reset", 16);

`ifdef FILTER_WINDOW_SOF_EN
    // Start-of-frame on pixel 20 realigns the frame
    pattern_phase = 0;
    win_cnt = 0;
    send(20, 0, 0, 0, -1, -1);
    send(64, 0, 0, 0, 0, -1);
    drain("sof", 16);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
